i2c_slave_byte_engine: RTL and testbench
========================================

I2C_SLAVE_BYTE_ENGINE -- requirements
Module: i2c_slave_byte_engine

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50: 7-bit slave address.
REQ-002 SHALL have parameter ADDR_MASK, default 7'h7F: address bits compared; bit=0 means don't-care.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, legal range 2..4: synchroniser depth on SCL and SDA.
REQ-004 SHALL have port i_clk, input, 1: single system clock; all logic on its rising edge.
REQ-005 SHALL have port i_reset_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port i_scl, input, 1: I2C clock from master; slave never stretches.
REQ-007 SHALL have port io_sda, inout tri, 1: open-drain data; driven 1'b0 or 1'bz only, never 1'b1.
REQ-008 SHALL have port o_rx_data, output, 8: last byte written by master.
REQ-009 SHALL have port o_rx_valid, output, 1: one-cycle pulse; o_rx_data is new.
REQ-010 SHALL have port i_rx_ready, input, 1: 1 = ACK the current write byte, 0 = NACK it.
REQ-011 SHALL have port i_tx_data, input, 8: byte returned on the next read slot.
REQ-012 SHALL have port o_tx_load, output, 1: one-cycle pulse; i_tx_data captured this cycle.
REQ-013 SHALL have port o_busy, output, 1: high from address match until STOP, repeated START or NACKed read.

Function
REQ-014 SHALL pass i_scl and io_sda through SYNC_STAGES flops; all detection uses the synchronised values and their previous-cycle copies.
REQ-015 SHALL detect START when synced SDA falls while synced SCL is high, and STOP when synced SDA rises while synced SCL is high.
REQ-016 SHALL sample SDA on a detected SCL rising edge and change its own SDA drive only on the cycle a SCL falling edge is detected.
REQ-017 SHALL implement states IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, IGNORE.
REQ-018 SHALL use a 3-bit bit counter, MSB-first, cleared on every START and at each byte boundary.
REQ-019 SHALL go from any state to ADDR on START, release SDA, clear the bit counter and drop o_busy; this covers repeated START.
REQ-020 SHALL go from any state to IDLE on STOP, release SDA and drop o_busy.
REQ-021 In ADDR, SHALL shift 8 bits (7 address bits + R/W); match is ((addr ^ SLAVE_ADDR) & ADDR_MASK) == 0.
REQ-022 On a match, at the SCL fall after bit 8, SHALL drive SDA low, set o_busy and enter ADDR_ACK; on no match it SHALL enter IGNORE with SDA released.
REQ-023 At the SCL fall ending ADDR_ACK: if R/W=0, SHALL release SDA and enter RX_BYTE; if R/W=1, SHALL capture i_tx_data, pulse o_tx_load, drive bit7 (low if 0, else z) and enter TX_BYTE.
REQ-024 In RX_BYTE, on the SCL rise of bit 8, SHALL update o_rx_data and pulse o_rx_valid for exactly one cycle.
REQ-025 At the SCL fall after bit 8 in RX_BYTE, SHALL sample i_rx_ready: if 1, drive SDA low; if 0, release SDA. It SHALL then enter RX_ACK.
REQ-026 At the SCL fall ending RX_ACK, SHALL release SDA; it SHALL return to RX_BYTE if the byte was ACKed, else go to IGNORE.
REQ-027 In TX_BYTE, SHALL present the next bit at each SCL fall; after bit 0 SHALL release SDA and enter TX_ACK.
REQ-028 In TX_ACK, on the SCL rise, SDA=0 (master ACK) SHALL cause, at the next SCL fall, a reload per REQ-023 and TX_BYTE; SDA=1 (NACK) SHALL cause IGNORE and drop o_busy.
REQ-029 IGNORE SHALL keep SDA released and leave only on START or STOP.
REQ-030 If START/STOP and an SCL edge are detected in the same cycle, START/STOP SHALL take priority.
REQ-031 While driving SDA low itself, the block SHALL NOT detect START/STOP caused by its own drive; detection applies only while SCL is high, and the block changes SDA only after SCL falls.

Reset
REQ-032 While i_reset_n=0: state IDLE, SDA released, o_rx_data=8'h00, o_rx_valid=0, o_tx_load=0, o_busy=0, counters 0.
REQ-033 Synchroniser flops SHALL reset to 1 (idle bus) so reset release never produces a false START/STOP.
REQ-034 Reset asserted mid-transfer SHALL release SDA asynchronously, with no wait for a clock edge.

Verification
REQ-035 Write 0xA0 then 0x3C, with i_rx_ready=1 -> ACK on address and data; o_rx_data=8'h3C; one o_rx_valid pulse.
REQ-036 Address 0x52, default mask -> no ACK, IGNORE, o_busy=0, SDA never driven until STOP.
REQ-037 ADDR_MASK=7'h7C, address 0x53 -> ACK.
REQ-038 Read 0xA1 with i_tx_data=8'hA5 then 8'h5A, master ACK then NACK -> bus shows A5, 5A; two o_tx_load pulses; IGNORE after NACK.
REQ-039 Write byte with i_rx_ready=0 -> SDA high in ACK slot, then IGNORE; repeated START + 0xA1 -> read proceeds.
REQ-040 i_reset_n low while slave drives ACK -> SDA goes z immediately; after release, IDLE with all outputs 0.

Source files
------------

// File: rtl/i2c_slave_byte_engine.sv
// i2c_slave_byte_engine
// Byte-level I2C slave: address match with a don't-care mask, write bytes
// handed out on o_rx_data/o_rx_valid with ACK/NACK chosen by i_rx_ready, and
// read bytes fetched from i_tx_data (o_tx_load marks each capture).
// The slave never stretches SCL and only ever pulls SDA low or releases it.
//
// Ports
//   i_clk       system clock, all logic on its rising edge
//   i_reset_n   asynchronous active-low reset
//   i_scl       I2C clock from the master
//   io_sda      open-drain I2C data
//   o_rx_data   last byte written by the master
//   o_rx_valid  one-cycle pulse when o_rx_data is updated
//   i_rx_ready  1 = ACK the current write byte, 0 = NACK it
//   i_tx_data   byte returned on the next read slot
//   o_tx_load   one-cycle pulse when i_tx_data is captured
//   o_busy      high from address match until STOP, repeated START or read NACK
module i2c_slave_byte_engine #(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h50,
  parameter logic [6:0]  ADDR_MASK   = 7'h7F,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_scl,
  inout  tri         io_sda,
  output logic [7:0] o_rx_data,
  output logic       o_rx_valid,
  input  logic       i_rx_ready,
  input  logic [7:0] i_tx_data,
  output logic       o_tx_load,
  output logic       o_busy
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StRxByte, StRxAck, StTxByte, StTxAck, StIgnore
  } state_e;

  // Synchronisers reset to 1 so releasing reset on an idle bus is silent.
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;
  logic                   scl_s, sda_s;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], i_scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], io_sda};
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  logic start_det, stop_det, scl_rise, scl_fall;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       byte_done_q, byte_done_d;  // 8 bits clocked in/out, act on next fall
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic       rw_q, rw_d;
  logic       acked_q, acked_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_load_q, tx_load_d;
  logic       load_tx;
  logic       addr_match;

  assign addr_match = ((shift_q[7:1] ^ SLAVE_ADDR) & ADDR_MASK) == 7'h00;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= 3'd0;
      byte_done_q <= 1'b0;
      shift_q     <= 8'h00;
      tx_shift_q  <= 8'h00;
      rw_q        <= 1'b0;
      acked_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_load_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
      shift_q     <= shift_d;
      tx_shift_q  <= tx_shift_d;
      rw_q        <= rw_d;
      acked_q     <= acked_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_load_q   <= tx_load_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_done_d = byte_done_q;
    shift_d     = shift_q;
    tx_shift_d  = tx_shift_q;
    rw_d        = rw_q;
    acked_d     = acked_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    tx_load_d   = 1'b0;
    load_tx     = 1'b0;

    if (start_det) begin
      state_d     = StAddr;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else if (stop_det) begin
      state_d     = StIdle;
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      sda_oe_d    = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        StAddr: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;  // wraps to 0 at the byte boundary
            if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            if (addr_match) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              rw_d     = shift_q[0];
              state_d  = StAddrAck;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StAddrAck: begin
          if (scl_fall) begin
            bit_cnt_d = 3'd0;
            if (rw_q) begin
              load_tx = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = StRxByte;
            end
          end
        end
        StRxByte: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_data_d   = {shift_q[6:0], sda_s};
              rx_valid_d  = 1'b1;
              byte_done_d = 1'b1;
            end
          end else if (scl_fall && byte_done_q) begin
            byte_done_d = 1'b0;
            acked_d     = i_rx_ready;
            sda_oe_d    = i_rx_ready;
            state_d     = StRxAck;
          end
        end
        StRxAck: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            state_d  = acked_q ? StRxByte : StIgnore;
          end
        end
        StTxByte: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) byte_done_d = 1'b1;
          end else if (scl_fall) begin
            if (byte_done_q) begin
              byte_done_d = 1'b0;
              sda_oe_d    = 1'b0;
              state_d     = StTxAck;
            end else begin
              sda_oe_d   = ~tx_shift_q[6];
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
            end
          end
        end
        StTxAck: begin
          // A fall here always follows an ACKed rise; NACK leaves on the rise.
          if (scl_rise && sda_s) begin
            state_d = StIgnore;
            busy_d  = 1'b0;
          end else if (scl_fall) begin
            load_tx = 1'b1;
          end
        end
        StIdle, StIgnore: sda_oe_d = 1'b0;
        default: begin
          state_d  = StIdle;
          sda_oe_d = 1'b0;
        end
      endcase
    end

    if (load_tx) begin
      tx_shift_d  = i_tx_data;
      tx_load_d   = 1'b1;
      sda_oe_d    = ~i_tx_data[7];
      bit_cnt_d   = 3'd0;
      byte_done_d = 1'b0;
      state_d     = StTxByte;
    end
  end

  // Reset gates the driver directly so SDA is released without a clock edge.
  assign io_sda     = (sda_oe_q && i_reset_n) ? 1'b0 : 1'bz;
  assign o_rx_data  = rx_data_q;
  assign o_rx_valid = rx_valid_q;
  assign o_tx_load  = tx_load_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave_byte_engine.sv
// Self-checking bench for i2c_slave_byte_engine: a bit-banged I2C master,
// a table of write transactions, and hand-written read / repeated-START /
// reset sequences. A second instance with ADDR_MASK=7'h7C sits on its own
// SDA wire to check masked address matching.
module tb_i2c_slave_byte_engine;

  localparam int H = 8;  // system clocks per SCL phase step

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       master_low = 1'b0;
  logic       rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;

  wire        sda_bus;
  wire        sda_bus2;
  assign sda_bus  = master_low ? 1'b0 : 1'bz;
  assign sda_bus2 = master_low ? 1'b0 : 1'bz;
  pullup (sda_bus);
  pullup (sda_bus2);

  logic [7:0] rx_data, rx_data_m;
  logic       rx_valid, rx_valid_m, tx_load, tx_load_m, busy, busy_m;

  i2c_slave_byte_engine u_dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_scl      (scl),
    .io_sda     (sda_bus),
    .o_rx_data  (rx_data),
    .o_rx_valid (rx_valid),
    .i_rx_ready (rx_ready),
    .i_tx_data  (tx_data),
    .o_tx_load  (tx_load),
    .o_busy     (busy)
  );

  i2c_slave_byte_engine #(.ADDR_MASK(7'h7C)) u_dut_mask (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_scl      (scl),
    .io_sda     (sda_bus2),
    .o_rx_data  (rx_data_m),
    .o_rx_valid (rx_valid_m),
    .i_rx_ready (rx_ready),
    .i_tx_data  (tx_data),
    .o_tx_load  (tx_load_m),
    .o_busy     (busy_m)
  );

  always #5 clk = ~clk;

  // Cumulative event monitors; tests look at differences.
  int valid_cnt = 0;
  int load_cnt  = 0;
  int low_cnt   = 0;  // cycles the DUT alone holds SDA low
  always @(negedge clk) begin
    if (rx_valid === 1'b1) valid_cnt <= valid_cnt + 1;
    if (tx_load === 1'b1) load_cnt <= load_cnt + 1;
    if (!master_low && sda_bus === 1'b0) low_cnt <= low_cnt + 1;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_start();
    master_low = 1'b0;
    clk_wait(H);
    scl = 1'b1;
    clk_wait(H);
    master_low = 1'b1;
    clk_wait(H);
    scl = 1'b0;
    clk_wait(H);
  endtask

  task automatic bus_stop();
    master_low = 1'b1;
    clk_wait(H);
    scl = 1'b1;
    clk_wait(H);
    master_low = 1'b0;
    clk_wait(H);
  endtask

  task automatic send_bit(input logic b, output logic s1, output logic s2);
    master_low = ~b;
    clk_wait(H);
    scl = 1'b1;
    clk_wait(H / 2);
    s1 = sda_bus;
    s2 = sda_bus2;
    clk_wait(H / 2);
    scl = 1'b0;
    clk_wait(H);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack1, output logic ack2);
    logic s1, s2;
    for (int i = 7; i >= 0; i--) send_bit(d[i], s1, s2);
    send_bit(1'b1, s1, s2);
    ack1 = ~s1;
    ack2 = ~s2;
  endtask

  task automatic read_data(output logic [7:0] d);
    logic s1, s2;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, s1, s2);
      d[i] = s1;
    end
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       rdy;
    logic       exp_aack;
    logic       exp_dack;
    logic [7:0] exp_rx;
    int         exp_valid;
  } wvec_t;

  wvec_t vecs[6];

  initial begin
    logic a1, a2, s1, s2;
    logic [7:0] rd;
    int base_v, base_l, base_low;

    vecs[0] = '{8'hA0, 8'h3C, 1'b1, 1'b1, 1'b1, 8'h3C, 1};
    vecs[1] = '{8'hA0, 8'h81, 1'b0, 1'b1, 1'b0, 8'h81, 1};
    vecs[2] = '{8'h52, 8'h11, 1'b1, 1'b0, 1'b0, 8'h81, 0};
    vecs[3] = '{8'hA0, 8'hFF, 1'b1, 1'b1, 1'b1, 8'hFF, 1};
    vecs[4] = '{8'hA0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1};
    vecs[5] = '{8'h50, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00, 0};

    clk_wait(4);
    check("rst_rx_data", {24'h0, rx_data}, 32'h00);
    check("rst_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("rst_tx_load", {31'h0, tx_load}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_sda_released", {31'h0, sda_bus}, 32'h1);
    rst_n = 1'b1;
    clk_wait(H);
    check("post_rst_busy", {31'h0, busy}, 32'h0);

    // Table of single-byte writes.
    for (int i = 0; i < 6; i++) begin
      base_v   = valid_cnt;
      base_low = low_cnt;
      bus_start();
      write_byte(vecs[i].addr, a1, a2);
      check($sformatf("v%0d_addr_ack", i), {31'h0, a1}, {31'h0, vecs[i].exp_aack});
      check($sformatf("v%0d_busy", i), {31'h0, busy}, {31'h0, vecs[i].exp_aack});
      rx_ready = vecs[i].rdy;
      write_byte(vecs[i].data, a1, a2);
      check($sformatf("v%0d_data_ack", i), {31'h0, a1}, {31'h0, vecs[i].exp_dack});
      check($sformatf("v%0d_rx_data", i), {24'h0, rx_data}, {24'h0, vecs[i].exp_rx});
      check($sformatf("v%0d_valid_cycles", i), valid_cnt - base_v, vecs[i].exp_valid);
      check($sformatf("v%0d_dut_drove", i), {31'h0, (low_cnt != base_low)},
            {31'h0, vecs[i].exp_aack});
      bus_stop();
      check($sformatf("v%0d_busy_after_stop", i), {31'h0, busy}, 32'h0);
      rx_ready = 1'b1;
    end

    // Two-byte write: ACK loops back to RX_BYTE.
    base_v = valid_cnt;
    bus_start();
    write_byte(8'hA0, a1, a2);
    write_byte(8'h12, a1, a2);
    check("mb_ack1", {31'h0, a1}, 32'h1);
    write_byte(8'h34, a1, a2);
    check("mb_ack2", {31'h0, a1}, 32'h1);
    check("mb_rx_data", {24'h0, rx_data}, 32'h34);
    check("mb_valid_cycles", valid_cnt - base_v, 2);
    bus_stop();

    // Masked address: 7-bit address 0x53 on the wire as 0xA6.
    bus_start();
    write_byte(8'hA6, a1, a2);
    check("mask_ack", {31'h0, a2}, 32'h1);
    check("mask_busy", {31'h0, busy_m}, 32'h1);
    check("nomask_nack", {31'h0, a1}, 32'h0);
    bus_stop();

    // Read A5 (master ACK) then 5A (master NACK).
    base_v = valid_cnt;
    base_l = load_cnt;
    tx_data = 8'hA5;
    bus_start();
    write_byte(8'hA1, a1, a2);
    check("rd_addr_ack", {31'h0, a1}, 32'h1);
    read_data(rd);
    check("rd_byte0", {24'h0, rd}, 32'hA5);
    tx_data = 8'h5A;
    send_bit(1'b0, s1, s2);
    read_data(rd);
    check("rd_byte1", {24'h0, rd}, 32'h5A);
    tx_data = 8'hFF;
    send_bit(1'b1, s1, s2);
    check("rd_busy_after_nack", {31'h0, busy}, 32'h0);
    check("rd_load_pulses", load_cnt - base_l, 2);
    check("rd_no_rx_valid", valid_cnt - base_v, 0);
    base_low = low_cnt;
    write_byte(8'h00, a1, a2);
    check("rd_ignore_nack", {31'h0, a1}, 32'h0);
    check("rd_ignore_no_drive", low_cnt - base_low, 0);
    bus_stop();

    // Write NACK, then repeated START into a read.
    rx_ready = 1'b0;
    bus_start();
    write_byte(8'hA0, a1, a2);
    check("rs_addr_ack", {31'h0, a1}, 32'h1);
    write_byte(8'h77, a1, a2);
    check("rs_data_nack", {31'h0, a1}, 32'h0);
    check("rs_rx_data", {24'h0, rx_data}, 32'h77);
    rx_ready = 1'b1;
    tx_data = 8'hC3;
    bus_start();
    write_byte(8'hA1, a1, a2);
    check("rs_read_addr_ack", {31'h0, a1}, 32'h1);
    read_data(rd);
    check("rs_read_byte", {24'h0, rd}, 32'hC3);
    send_bit(1'b1, s1, s2);
    bus_stop();

    // Reset while the slave is driving the address ACK.
    bus_start();
    for (int i = 7; i >= 0; i--) send_bit(((8'hA0 >> i) & 8'h01) != 0, s1, s2);
    master_low = 1'b0;
    clk_wait(2);
    check("rst_ack_driven", {31'h0, sda_bus}, 32'h0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_release", {31'h0, sda_bus}, 32'h1);
    clk_wait(3);
    rst_n = 1'b1;
    clk_wait(3);
    check("rst2_rx_data", {24'h0, rx_data}, 32'h00);
    check("rst2_rx_valid", {31'h0, rx_valid}, 32'h0);
    check("rst2_tx_load", {31'h0, tx_load}, 32'h0);
    check("rst2_busy", {31'h0, busy}, 32'h0);
    bus_stop();

    // Normal operation after reset.
    bus_start();
    write_byte(8'hA0, a1, a2);
    check("post_rst_addr_ack", {31'h0, a1}, 32'h1);
    write_byte(8'h3C, a1, a2);
    check("post_rst_rx_data", {24'h0, rx_data}, 32'h3C);
    bus_stop();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
